// File: rtl/audio_mix_sched.sv
// Four-voice audio mixer with a sample-rate frame scheduler. Once per sample period it
// requests one sample from each enabled voice, sums and saturates them, and drives an
// offset-binary PCM word to the DAC together with the DAC sample clock.
module audio_mix_sched #(
  parameter int unsigned BITDEPTH = 12,
  parameter int unsigned DIVIDER  = 256,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            voice_en,
  output logic [3:0]            req,
  input  logic [3:0]            smp_valid,
  input  logic [4*BITDEPTH-1:0] smp_data,
  input  logic                  underrun_clr,
  output logic [3:0]            underrun,
  output logic                  sample_clock,
  output logic [BITDEPTH-1:0]   pcm
);

  localparam int unsigned CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int unsigned AW = BITDEPTH + 2;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BITDEPTH-1:0] MIDSCALE = {1'b1, {(BITDEPTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, VOICE, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [1:0]            idx;
  logic [3:0]            en_cap;
  logic [TW-1:0]         tmr;
  logic signed [AW-1:0]  acc;
  logic [BITDEPTH-1:0]   result;

  logic                  tick_c;
  logic                  half_c;
  logic                  accept_c;
  logic                  timeout_c;
  logic                  adv_c;
  logic [1:0]            nxt_idx_c;
  logic [BITDEPTH-1:0]   cur_data_c;
  logic signed [AW-1:0]  cur_ext_c;
  logic [3:0]            set_c;
  logic [2:0]            upper_c;
  logic [BITDEPTH-1:0]   sat_c;
  logic [BITDEPTH-1:0]   offs_c;

  // Frame timing, handshake decode and output saturation
  always_comb begin
    tick_c     = 1'b0;
    half_c     = 1'b0;
    accept_c   = 1'b0;
    timeout_c  = 1'b0;
    adv_c      = 1'b0;
    nxt_idx_c  = idx + 2'd1;
    cur_data_c = smp_data[idx*BITDEPTH +: BITDEPTH];
    cur_ext_c  = {{2{cur_data_c[BITDEPTH-1]}}, cur_data_c};
    set_c      = 4'b0;
    upper_c    = acc[AW-1:BITDEPTH-1];
    sat_c      = acc[BITDEPTH-1:0];

    tick_c = (cnt == CW'(DIVIDER - 1));
    half_c = (cnt == CW'(DIVIDER/2 - 1));

    if (state == VOICE) begin
      accept_c  = req[idx] && smp_valid[idx];
      timeout_c = req[idx] && !smp_valid[idx] && (tmr == TW'(TIMEOUT - 1));
      adv_c     = !en_cap[idx] || accept_c || timeout_c;
    end
    if (timeout_c) set_c = 4'(4'b1 << idx);

    // Clamp only when the guard bits disagree with the sign
    if (!acc[AW-1] && (|upper_c))
      sat_c = {1'b0, {(BITDEPTH-1){1'b1}}};
    else if (acc[AW-1] && !(&upper_c))
      sat_c = {1'b1, {(BITDEPTH-1){1'b0}}};
    offs_c = {~sat_c[BITDEPTH-1], sat_c[BITDEPTH-2:0]};
  end

  // Sample-rate divider, DAC outputs, underrun flags and voice scheduler
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      state        <= IDLE;
      idx          <= 2'd0;
      en_cap       <= 4'b0;
      tmr          <= '0;
      acc          <= '0;
      req          <= 4'b0;
      underrun     <= 4'b0;
      sample_clock <= 1'b0;
      result       <= MIDSCALE;
      pcm          <= MIDSCALE;
    end else begin
      cnt <= tick_c ? '0 : cnt + CW'(1);

      if (tick_c)      sample_clock <= 1'b1;
      else if (half_c) sample_clock <= 1'b0;

      // A fresh timeout beats a simultaneous clear
      underrun <= (underrun & ~{4{underrun_clr}}) | set_c;

      if (tick_c) pcm <= result;

      if (tick_c) begin
        state  <= VOICE;
        idx    <= 2'd0;
        acc    <= '0;
        en_cap <= voice_en;
        tmr    <= '0;
        req    <= {3'b0, voice_en[0]};
      end else begin
        case (state)
          IDLE: ;
          VOICE: begin
            if (adv_c) begin
              if (accept_c) acc <= acc + cur_ext_c;
              tmr <= '0;
              if (idx == 2'd3) begin
                state <= DONE;
                req   <= 4'b0;
              end else begin
                idx <= nxt_idx_c;
                req <= en_cap[nxt_idx_c] ? 4'(4'b1 << nxt_idx_c) : 4'b0;
              end
            end else if (req[idx]) begin
              tmr <= tmr + TW'(1);
            end
          end
          DONE: begin
            result <= offs_c;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/audio_mix_sched.md
AUDIO_MIX_SCHED -- requirements
Module: audio_mix_sched

Interface
REQ-001 Parameter BITDEPTH, default 12, sample width of each voice and of pcm.
REQ-002 Parameter DIVIDER, default 256, clk cycles per sample period; SHALL satisfy DIVIDER >= 4*(TIMEOUT+2)+4 and be even.
REQ-003 Parameter TIMEOUT, default 15, max cycles req is held per voice.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 voice_en  input  4  per-voice enable.
REQ-007 req  output  4  per-voice sample request, at most one bit high.
REQ-008 smp_valid  input  4  per-voice sample valid.
REQ-009 smp_data  input  4*BITDEPTH  voice i sample in bits [i*BITDEPTH +: BITDEPTH], two's complement.
REQ-010 underrun_clr  input  1  clears underrun flags.
REQ-011 underrun  output  4  sticky per-voice timeout flags.
REQ-012 sample_clock  output  1  registered sample-rate square wave for the DAC.
REQ-013 pcm  output  BITDEPTH  offset-binary mixed sample to the DAC.

Function
REQ-014 Free-running counter 0..DIVIDER-1 SHALL wrap to 0; the tick is the cycle with counter == DIVIDER-1.
REQ-015 sample_clock SHALL go 1 on the edge ending the tick and go 0 on the edge ending the cycle with counter == DIVIDER/2-1, giving a 50% duty cycle with period DIVIDER.
REQ-016 pcm SHALL update only on the edge ending a tick, loading the result of the previous frame (one-sample latency).
REQ-017 Each tick SHALL start a frame: clear the accumulator (BITDEPTH+2 bits, signed), capture voice_en, and set the voice index to 0.
REQ-018 States: IDLE, VOICE, DONE; IDLE->VOICE on tick; VOICE->DONE after voice 3; DONE->IDLE after 1 cycle.
REQ-019 For a disabled voice (captured enable = 0), VOICE SHALL spend 1 cycle, leave req low, and advance.
REQ-020 For an enabled voice, req[i] SHALL rise on entering the voice and stay high until accept or timeout.
REQ-021 Accept: in a cycle with req[i] = 1 and smp_valid[i] = 1, the accumulator SHALL add sign-extended smp_data[i]; req[i] SHALL be low next cycle and the index SHALL advance.
REQ-022 Timeout: if req[i] has been high TIMEOUT cycles without accept, req[i] SHALL drop, the voice SHALL contribute 0, underrun[i] SHALL set, and the index SHALL advance.
REQ-023 smp_valid on a voice whose req is low SHALL be ignored.
REQ-024 DONE SHALL saturate the accumulator to [-2^(BITDEPTH-1), 2^(BITDEPTH-1)-1], invert the MSB (offset binary), and store it in the result register.
REQ-025 underrun_clr SHALL clear all flags; if a set and a clear occur in the same cycle, the set SHALL win for that bit.
REQ-026 Changes to voice_en mid-frame SHALL take effect at the next frame.

Reset
REQ-027 On rst: counter = 0, state = IDLE, req = 0, underrun = 0, sample_clock = 0, accumulator = 0, result = 2^(BITDEPTH-1), pcm = 2^(BITDEPTH-1).
REQ-028 Reset mid-frame SHALL abandon the frame with no flag or pcm side effects; the first tick after reset is DIVIDER cycles after rst deasserts.

Verification (BITDEPTH=12, DIVIDER=256, TIMEOUT=15)
REQ-029 All voice_en = 0 -> req never high, pcm stays 0x800, sample_clock period 256 with high time 128.
REQ-030 Only voice0 enabled, valid the same cycle req rises, data 0x100 -> req[0] high 1 cycle per frame; pcm = 0x800 at first tick, 0x900 from the second tick.
REQ-031 All four enabled with data 0x7FF -> pcm = 0xFFF; with data 0x800 -> pcm = 0x000; with voice0 = 0x7FF and voice1 = 0x801 -> pcm = 0x800.
REQ-032 Voice2 enabled, never valid -> req[2] high exactly 15 cycles, underrun[2] = 1, contribution 0; underrun_clr pulse clears the flag; clr coinciding with the timeout leaves underrun[2] = 1.
REQ-033 rst asserted while req[1] is high -> next cycle req = 0, pcm = 0x800, underrun = 0, sample_clock = 0, next tick 256 cycles after release.
REQ-034 voice_en[3] raised mid-frame after voice3 is reached -> no req[3] that frame; req[3] is asserted in the following frame.
